// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider.
// The master drives the controls and the slave (the divider) returns the divided outputs.
interface clk_div_prog_if #(
  parameter int CNT_W = 32
);
  logic             en;
  logic             sync_clr;
  logic             pulse_mode;
  logic             load;
  logic [CNT_W-1:0] half_period_in;
  logic             sclk;
  logic             tick_rise;
  logic             tick_fall;
  logic             pending;

  modport master (
    output en, sync_clr, pulse_mode, load, half_period_in,
    input  sclk, tick_rise, tick_fall, pending
  );

  modport slave (
    input  en, sync_clr, pulse_mode, load, half_period_in,
    output sclk, tick_rise, tick_fall, pending
  );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable divider: square wave or strobe on sclk, with rise/fall ticks.
// A new half-period is staged in a shadow register and takes effect only at a terminal count.
module clk_div_prog #(
  parameter int               CNT_W        = 32,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = 25000000
) (
  input  logic           clk,
  input  logic           rst,
  clk_div_prog_if.slave  bus
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active_half;
  logic [CNT_W-1:0] shadow;
  logic             pending_q;
  logic             mode_q;
  logic             sclk_q;
  logic             tick_rise_q;
  logic             tick_fall_q;

  logic             mode_chg;
  logic             at_boundary;
  logic             staged_valid;
  logic [CNT_W-1:0] staged_half;

  assign mode_chg     = (bus.pulse_mode != mode_q);
  assign at_boundary  = (cnt == active_half);
  // A same-cycle load beats an older shadow value.
  assign staged_valid = bus.load | pending_q;
  assign staged_half  = bus.load ? bus.half_period_in : shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      active_half <= DEFAULT_HALF;
      shadow      <= DEFAULT_HALF;
      pending_q   <= 1'b0;
      mode_q      <= 1'b0;
      sclk_q      <= 1'b0;
      tick_rise_q <= 1'b0;
      tick_fall_q <= 1'b0;
    end else begin
      mode_q      <= bus.pulse_mode;
      tick_rise_q <= 1'b0;
      tick_fall_q <= 1'b0;
      if (bus.load) shadow <= bus.half_period_in;

      if (bus.sync_clr) begin
        cnt       <= '0;
        sclk_q    <= 1'b0;
        pending_q <= 1'b0;
        if (staged_valid) active_half <= staged_half;
      end else if (mode_chg) begin
        cnt    <= '0;
        sclk_q <= 1'b0;
        if (bus.load) begin
          if (bus.en) begin
            pending_q <= 1'b1;
          end else begin
            active_half <= bus.half_period_in;
            pending_q   <= 1'b0;
          end
        end
      end else if (!bus.en) begin
        if (bus.pulse_mode) sclk_q <= 1'b0;
        // Frozen divider has no boundary to wait for, so apply at once.
        if (bus.load) begin
          active_half <= bus.half_period_in;
          cnt         <= '0;
          pending_q   <= 1'b0;
        end
      end else if (at_boundary) begin
        cnt       <= '0;
        pending_q <= 1'b0;
        if (staged_valid) active_half <= staged_half;
        if (bus.pulse_mode) begin
          sclk_q      <= 1'b1;
          tick_rise_q <= 1'b1;
        end else begin
          sclk_q      <= ~sclk_q;
          tick_rise_q <= ~sclk_q;
          tick_fall_q <= sclk_q;
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (bus.pulse_mode) sclk_q <= 1'b0;
        if (bus.load) pending_q <= 1'b1;
      end
    end
  end

  assign bus.sclk      = sclk_q;
  assign bus.tick_rise = tick_rise_q;
  assign bus.tick_fall = tick_fall_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios with literal expectations, then random stimulus,
// all outputs compared every cycle against a countdown-based behavioural model.
module tb_clk_div_prog;
  localparam int CW  = 8;
  localparam int DEF = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clk_div_prog_if #(.CNT_W(CW)) bus ();

  clk_div_prog #(.CNT_W(CW), .DEFAULT_HALF(8'(DEF))) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: m_left = clk edges still to go before the next terminal count.
  int m_half, m_shadow, m_left;
  bit m_pend, m_sclk, m_rise, m_fall, m_mode, m_valid, mode_chg;

  always @(posedge clk) begin
    if (rst) begin
      m_half = DEF; m_shadow = DEF; m_left = DEF; m_pend = 0;
      m_sclk = 0; m_rise = 0; m_fall = 0; m_mode = 0;
    end else begin
      mode_chg = (bus.pulse_mode != m_mode);
      m_mode   = bus.pulse_mode;
      m_rise   = 0;
      m_fall   = 0;
      if (bus.sync_clr) begin
        if (bus.load) m_half = int'(bus.half_period_in);
        else if (m_pend) m_half = m_shadow;
        m_pend = 0; m_left = m_half; m_sclk = 0;
      end else if (mode_chg) begin
        m_sclk = 0;
        if (bus.load && bus.en) begin
          m_shadow = int'(bus.half_period_in); m_pend = 1;
        end else if (bus.load) begin
          m_half = int'(bus.half_period_in); m_pend = 0;
        end
        m_left = m_half;
      end else if (!bus.en) begin
        if (bus.pulse_mode) m_sclk = 0;
        if (bus.load) begin
          m_half = int'(bus.half_period_in); m_pend = 0; m_left = m_half;
        end
      end else if (m_left == 0) begin
        if (bus.load) m_half = int'(bus.half_period_in);
        else if (m_pend) m_half = m_shadow;
        m_pend = 0;
        m_left = m_half;
        if (bus.pulse_mode) begin
          m_sclk = 1; m_rise = 1;
        end else begin
          m_rise = !m_sclk; m_fall = m_sclk; m_sclk = !m_sclk;
        end
      end else begin
        m_left = m_left - 1;
        if (bus.pulse_mode) m_sclk = 0;
        if (bus.load) begin
          m_shadow = int'(bus.half_period_in); m_pend = 1;
        end
      end
    end
    m_valid = 1;
  end

  task automatic cmp(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s t=%0t actual=%b required=%b", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      cmp("model_sclk",      bus.sclk,      m_sclk);
      cmp("model_tick_rise", bus.tick_rise, m_rise);
      cmp("model_tick_fall", bus.tick_fall, m_fall);
      cmp("model_pending",   bus.pending,   m_pend);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.sync_clr = 1'b0; bus.pulse_mode = 1'b0;
    bus.load = 1'b0; bus.half_period_in = '0;
    step(2);
    cmp("reset_sclk", bus.sclk, 1'b0);
    cmp("reset_pending", bus.pending, 1'b0);
    cmp("reset_ticks", bus.tick_rise | bus.tick_fall, 1'b0);

    // Default H=3: rise 4 edges after release, fall 4 edges later.
    rst = 1'b0; bus.en = 1'b1;
    step(4);
    cmp("first_rise", bus.tick_rise, 1'b1);
    cmp("first_rise_sclk", bus.sclk, 1'b1);
    step(1);
    cmp("rise_one_wide", bus.tick_rise, 1'b0);
    step(3);
    cmp("first_fall", bus.tick_fall, 1'b1);
    cmp("first_fall_sclk", bus.sclk, 1'b0);

    // Load H=1 at cnt=1: old half finishes, then 2-cycle halves.
    step(1);
    bus.load = 1'b1; bus.half_period_in = 8'd1;
    step(1);
    bus.load = 1'b0;
    cmp("load_pending", bus.pending, 1'b1);
    step(2);
    cmp("old_half_done", bus.tick_rise, 1'b1);
    cmp("pending_cleared", bus.pending, 1'b0);
    step(2);
    cmp("short_half_fall", bus.tick_fall, 1'b1);

    // Load H=0 exactly on a boundary: applied there, divide-by-2 follows.
    step(1);
    bus.load = 1'b1; bus.half_period_in = 8'd0;
    step(1);
    bus.load = 1'b0;
    cmp("bnd_load_no_pending", bus.pending, 1'b0);
    cmp("bnd_load_rise", bus.tick_rise, 1'b1);
    step(1);
    cmp("div2_fall", bus.tick_fall, 1'b1);
    step(1);
    cmp("div2_rise", bus.tick_rise, 1'b1);
    bus.load = 1'b1; bus.half_period_in = 8'd3;
    step(1);
    bus.load = 1'b0;
    step(3);

    // Square -> pulse mode.
    bus.pulse_mode = 1'b1;
    step(1);
    cmp("mode_chg_sclk", bus.sclk, 1'b0);
    step(3);
    cmp("pulse_low", bus.sclk, 1'b0);
    step(1);
    cmp("pulse_strobe", bus.sclk, 1'b1);
    cmp("pulse_rise", bus.tick_rise, 1'b1);
    cmp("pulse_no_fall", bus.tick_fall, 1'b0);
    step(1);
    cmp("pulse_one_wide", bus.sclk, 1'b0);

    // Back to square, freeze at cnt=2 for 5 cycles.
    bus.pulse_mode = 1'b0;
    step(3);
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      cmp("frozen_quiet", bus.sclk | bus.tick_rise | bus.tick_fall, 1'b0);
    end
    bus.en = 1'b1;
    step(1);
    cmp("resume_not_yet", bus.sclk, 1'b0);
    step(1);
    cmp("resume_rise", bus.tick_rise, 1'b1);

    // sync_clr with sclk=1 and pending H=5.
    bus.load = 1'b1; bus.half_period_in = 8'd5;
    step(1);
    bus.load = 1'b0;
    cmp("pend5", bus.pending, 1'b1);
    bus.sync_clr = 1'b1;
    step(1);
    bus.sync_clr = 1'b0;
    cmp("clr_sclk", bus.sclk, 1'b0);
    cmp("clr_pending", bus.pending, 1'b0);
    step(5);
    cmp("h5_not_yet", bus.sclk, 1'b0);
    step(1);
    cmp("h5_rise", bus.tick_rise, 1'b1);

    // Reset mid-run discards a pending load and restores H=3.
    bus.load = 1'b1; bus.half_period_in = 8'd6;
    step(1);
    bus.load = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    cmp("rst_discard", bus.pending, 1'b0);
    step(4);
    cmp("rst_h3_rise", bus.tick_rise, 1'b1);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      step(1);
      rst                = ($urandom_range(0, 299) == 0);
      bus.en             = ($urandom_range(0, 9) != 0);
      bus.sync_clr       = ($urandom_range(0, 49) == 0);
      bus.load           = ($urandom_range(0, 7) == 0);
      bus.half_period_in = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 59) == 0) bus.pulse_mode = ~bus.pulse_mode;
    end
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Runtime-programmable clock-enable/divider generator. Parametrised in counter width and reset-default half-period.
Produces a divided square wave or a one-cycle strobe, plus single-cycle rise/fall tick strobes for downstream logic in the same `clk` domain (display refresh, MAC sequencing).
The half-period is reloadable while running and is applied glitch-free at the next boundary.

Parameters:
- CNT_W, 32, counter and half-period width in bits. Must hold DEFAULT_HALF.
- DEFAULT_HALF, 25000000, half-period terminal count after reset. Square-mode period = 2*(DEFAULT_HALF+1) `clk` cycles.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  count enable; low = freeze
- sync_clr  input  1  synchronous phase restart
- pulse_mode  input  1  0 = square wave on sclk, 1 = one-cycle strobe on sclk
- load  input  1  one-cycle request to load half_period_in
- half_period_in  input  CNT_W  new terminal count H
- sclk  output  1  divided clock or strobe (registered)
- tick_rise  output  1  one-cycle pulse, registered with sclk 0->1
- tick_fall  output  1  one-cycle pulse, registered with sclk 1->0 (square mode only)
- pending  output  1  shadow value waiting for next boundary

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - cnt=0, sclk=0, tick_rise=0, tick_fall=0, pending=0.
  - active_half=DEFAULT_HALF, shadow=DEFAULT_HALF, mode_q=0.
- Priority per cycle: rst > sync_clr > mode change > en/count. load capture is independent of the count path; it is overridden only by rst.
- Boundary: en=1 and cnt==active_half.
  - cnt<=0.
  - If pending: active_half<=shadow, pending<=0.
- Non-boundary with en=1: cnt<=cnt+1, sclk holds (square mode), ticks 0.
- Square mode (pulse_mode=0) at a boundary:
  - sclk<=~sclk.
  - tick_rise<=1 if old sclk=0; tick_fall<=1 if old sclk=1.
  - Period 2*(H+1). H=0 gives divide-by-2.
- Pulse mode (pulse_mode=1):
  - sclk<=1 and tick_rise<=1 for exactly the cycle after the boundary; 0 otherwise.
  - tick_fall stays 0.
  - Period H+1. H=0 gives sclk constant 1 while en=1.
- Ticks are strictly one cycle wide. They are never asserted when en=0 or in any cycle where rst or sync_clr is asserted.
- en=0: cnt, sclk, active_half hold. Ticks 0. In pulse mode sclk<=0.
- load while en=1:
  - shadow<=half_period_in, pending<=1.
  - The value is applied at the next boundary. A later load before that boundary overwrites shadow; last value wins.
- load coinciding with a boundary: the new value is applied at that same boundary (active_half<=half_period_in), pending ends 0.
- load while en=0: immediate apply. active_half<=half_period_in, cnt<=0, pending<=0. sclk holds.
- sync_clr:
  - cnt<=0, sclk<=0, ticks 0.
  - A pending shadow is applied immediately.
  - A load in the same cycle is applied immediately.
- Mode change: mode_q registers pulse_mode. If pulse_mode!=mode_q then cnt<=0, sclk<=0, ticks 0 for that cycle; counting resumes next cycle.
- No wrap-around: cnt compares with ==. If a load lowers H below the current cnt, the new value still applies only at a boundary of the old active_half, so cnt never overshoots.
- Reset mid-operation: all state returns to reset values next edge; a pending load is discarded.

Test Plan (DEFAULT_HALF=3, CNT_W=8 unless noted):
- Reset release, en=1, square mode -> sclk toggles every 4 cycles (period 8). tick_rise at cycles 4,12,...; tick_fall at 8,16,... after release. Each tick is 1 cycle wide.
- load H=1 mid-half at cnt=1 -> pending=1. Current half completes at 4 cycles; following halves are 2 cycles; pending clears at the boundary.
- Boundary+load same cycle with H=0 -> the next half is 1 cycle (divide-by-2), pending stays 0.
- pulse_mode 0->1 while running -> sclk=0 the next cycle, then sclk=tick_rise=1 for one cycle every 4 cycles; tick_fall never asserts.
- en dropped for 5 cycles at cnt=2 -> sclk and cnt frozen, no ticks. After en returns, the boundary occurs 2 cycles later.
- sync_clr with sclk=1 and pending H=5 -> next cycle sclk=0, cnt=0, H=5 active; first toggle occurs 6 cycles later. rst asserted mid-run restores H=3 and discards pending.
